// File: rtl/three_input_pattern_sequencer.sv
// Pattern sequencer: sweeps {a,b,c} through 000..111, timed or single-stepped.
// Optional macro STEP_DEBOUNCE_EN adds a step synchronizer plus debouncer.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   begin a sweep (IDLE or DONE only)
//   step_mode  in   0 = timed advance, 1 = manual advance on step
//   step       in   manual advance request (button level)
//   a, b, c    out  pattern bits 2..0 to the gate inputs
//   index      out  current pattern number, equals {a,b,c}
//   valid      out  high while a sweep presents a pattern
//   done       out  high after pattern 111 completes, until restart
module three_input_pattern_sequencer #(
  parameter int HOLD_CYCLES     = 20,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       step_mode,
  input  logic       step,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [2:0] index,
  output logic       valid,
  output logic       done
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CntLast = CW'(HOLD_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, done_q;
  logic          qual;
  logic          qual_prev_q;
  logic          step_edge;

`ifdef STEP_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DbLast = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          lvl_q;
  logic [DW-1:0] dcnt_q;

  // Counts consecutive samples that disagree with the accepted level;
  // any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      sync1_q <= step;
      sync2_q <= sync1_q;
      if (sync2_q == lvl_q) begin
        dcnt_q <= '0;
      end else if (dcnt_q == DbLast) begin
        lvl_q  <= sync2_q;
        dcnt_q <= '0;
      end else begin
        dcnt_q <= dcnt_q + DW'(1);
      end
    end
  end

  assign qual = lvl_q;
`else
  // step is already synchronous here; debounce depth has no effect.
  if (DEBOUNCE_CYCLES < 1) begin : g_db_unused
  end

  assign qual = step;
`endif

  assign step_edge = qual & ~qual_prev_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = 3'd0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        // Manual mode parks the counter at 0, so a switch to timed
        // mode always starts a fresh hold period.
        if (step_mode) begin
          cnt_d = '0;
          if (step_edge) begin
            if (idx_q == 3'd7) state_d = S_DONE;
            else idx_d = idx_q + 3'd1;
          end
        end else if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (idx_q == 3'd7) state_d = S_DONE;
          else idx_d = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      qual_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      valid_q     <= (state_d == S_RUN);
      done_q      <= (state_d == S_DONE);
      qual_prev_q <= qual;
    end
  end

  assign a     = idx_q[2];
  assign b     = idx_q[1];
  assign c     = idx_q[0];
  assign index = idx_q;
  assign valid = valid_q;
  assign done  = done_q;

endmodule

// File: tb/tb_three_input_pattern_sequencer.sv
// Bench for three_input_pattern_sequencer: directed sweeps plus random
// stimulus against a cycle-level reference model.
module tb_three_input_pattern_sequencer;

  localparam int HOLD = 4;
  localparam int DB   = 16;
`ifdef STEP_DEBOUNCE_EN
  localparam int LAT  = DB + 3;
  localparam int PW   = DB + 2;
  localparam int SPR  = 23;
`else
  localparam int LAT  = 1;
  localparam int PW   = 1;
  localparam int SPR  = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       step_mode;
  logic       step;
  logic       a, b, c;
  logic [2:0] index;
  logic       valid;
  logic       done;

  int errors = 0;
  int checks = 0;

  // model: 0 idle, 1 presenting, 2 finished
  int ms, midx, mel;
  bit mqprev, mdeb;
  bit hist[$];

  always #5 clk = ~clk;

  three_input_pattern_sequencer #(
    .HOLD_CYCLES(HOLD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .step_mode(step_mode),
    .step(step),
    .a(a),
    .b(b),
    .c(c),
    .index(index),
    .valid(valid),
    .done(done)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] obs_vec();
    return {index, a, b, c, valid, done};
  endfunction

  function automatic logic [7:0] exp_vec();
    logic [2:0] p;
    p = midx[2:0];
    return {p, p, ms == 1, ms == 2};
  endfunction

  task automatic model_reset();
    ms = 0;
    midx = 0;
    mel = 0;
    mqprev = 0;
    mdeb = 0;
    hist.delete();
  endtask

  task automatic next_pattern();
    if (midx == 7) ms = 2;
    else midx++;
  endtask

  task automatic model_edge();
    bit qn, adv;
`ifdef STEP_DEBOUNCE_EN
    bit all1, all0, s;
    qn = mdeb;
    hist.push_front(step);
    if (hist.size() > DB + 2) void'(hist.pop_back());
    // new level once the last DB samples, seen 2 cycles late, agree
    all1 = 1;
    all0 = 1;
    for (int i = 2; i < DB + 2; i++) begin
      s = (i < hist.size()) ? hist[i] : 1'b0;
      if (s) all0 = 0;
      else all1 = 0;
    end
    if (all1) mdeb = 1;
    else if (all0) mdeb = 0;
`else
    qn = step;
`endif
    adv = qn && !mqprev;
    mqprev = qn;
    case (ms)
      1: begin
        if (step_mode) begin
          mel = 0;
          if (adv) next_pattern();
        end else begin
          mel++;
          if (mel == HOLD) begin
            mel = 0;
            next_pattern();
          end
        end
      end
      default: begin
        if (start) begin
          ms = 1;
          midx = 0;
          mel = 0;
        end
      end
    endcase
  endtask

  // called at a negedge; returns at the following negedge
  task automatic drive(input bit st, input bit md, input bit sp);
    start = st;
    step_mode = md;
    step = sp;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model", obs_vec(), exp_vec());
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1 chk("rst_async", obs_vec(), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold", obs_vec(), 0);
    rst = 1'b0;
  endtask

  task automatic press();
    repeat (PW) drive(0, 1, 1);
    repeat (LAT + 2) drive(0, 1, 0);
  endtask

  initial begin
    int n, lat;
    logic [2:0] base;
    bit r_md, r_sp;

    rst = 1'b1;
    start = 1'b0;
    step_mode = 1'b0;
    step = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset", obs_vec(), 0);
    rst = 1'b0;

    // timed sweep
    drive(1, 0, 0);
    n = 0;
    while (valid && n < 100) begin
      n++;
      drive(0, 0, 0);
    end
    chk("valid_len", n, 32);
    chk("sweep_end", {index, valid, done}, {3'd7, 1'b0, 1'b1});
    repeat (3) drive(0, 0, 0);
    chk("done_hold", {index, a, b, c, done}, {3'd7, 3'd7, 1'b1});

    // restart from DONE
    drive(1, 0, 0);
    chk("restart", {index, valid, done}, {3'd0, 1'b1, 1'b0});

    // start during RUN is ignored
    n = 0;
    while (index != 3'd2 && n < 50) begin
      n++;
      drive(0, 0, 0);
    end
    drive(1, 0, 0);
    chk("start_in_run", {index, valid}, {3'd2, 1'b1});

    // asynchronous reset mid-sweep
    n = 0;
    while (index != 3'd5 && n < 100) begin
      n++;
      drive(0, 0, 0);
    end
    chk("reach5", index, 5);
    async_reset();
    repeat (4) drive(0, 0, 0);
    chk("idle_after_rst", obs_vec(), 0);

    // manual stepping
    drive(1, 1, 0);
`ifdef STEP_DEBOUNCE_EN
    repeat (5) drive(0, 1, 1);
    repeat (30) drive(0, 1, 0);
    chk("glitch", index, 0);
`else
    repeat (3) begin
      drive(0, 1, 1);
      repeat (4) drive(0, 1, 0);
    end
    chk("manual3", index, 3);
`endif
    base = index;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      drive(0, 1, 1);
      if (lat == 0 && index != base) lat = i;
    end
    repeat (LAT + 2) drive(0, 1, 0);
    chk("step_latency", lat, LAT);
    chk("one_advance", index, base + 3'd1);

    n = 0;
    while (index != 3'd7 && n < 10) begin
      n++;
      press();
    end
    chk("at7", {index, valid, done}, {3'd7, 1'b1, 1'b0});
    press();
    chk("done_manual", obs_vec(), {3'd7, 3'd7, 1'b0, 1'b1});

    // random traffic
    r_md = 0;
    r_sp = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end else begin
        if ($urandom_range(0, 79) == 0) r_md = ~r_md;
        if ($urandom_range(0, SPR) == 0) r_sp = ~r_sp;
        drive($urandom_range(0, 39) == 0, r_md, r_sp);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
